// File: rtl/core_register_file.sv
// rtl/core_register_file.sv - 16-entry architectural register file with auto-incrementing PC
// Indices 0x0-0x2 and 0xE are constants with no storage; 0x3-0xD are general purpose; 0xF is the PC.
module core_register_file #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            addr_read,
    input  logic [3:0]            addr_write,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] bus_datain,
    input  logic                  bus_fromin,
    input  logic                  pc_inc,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] reg_h_out
);

    localparam logic [3:0] IDX_ZERO = 4'h0;
    localparam logic [3:0] IDX_ONE  = 4'h1;
    localparam logic [3:0] IDX_NEG1 = 4'h2;
    localparam logic [3:0] IDX_GP_LO = 4'h3;
    localparam logic [3:0] IDX_GP_HI = 4'hD;
    localparam logic [3:0] IDX_H    = 4'hA;
    localparam logic [3:0] IDX_BUS  = 4'hE;
    localparam logic [3:0] IDX_PC   = 4'hF;

    logic [DATA_WIDTH-1:0] gp_regs [IDX_GP_LO:IDX_GP_HI];
    logic [DATA_WIDTH-1:0] pc;

    logic gp_write;
    logic pc_write;

    assign gp_write = write_enable && (addr_write >= IDX_GP_LO) && (addr_write <= IDX_GP_HI);
    assign pc_write = write_enable && (addr_write == IDX_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = IDX_GP_LO; i <= IDX_GP_HI; i++) begin
                gp_regs[i] <= '0;
            end
        end else if (gp_write) begin
            gp_regs[addr_write] <= data_write;
        end
    end

    // An explicit PC write beats the increment so a jump lands exactly on its target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_RESET;
        end else if (pc_write) begin
            pc <= data_write;
        end else if (pc_inc) begin
            pc <= pc + DATA_WIDTH'(1);
        end
    end

    // No write bypass: a same-cycle write to addr_read shows up only after the edge.
    always_comb begin
        data_read = '0;
        if (bus_fromin) begin
            data_read = bus_datain;
        end else begin
            case (addr_read)
                IDX_ZERO: data_read = '0;
                IDX_ONE:  data_read = DATA_WIDTH'(1);
                IDX_NEG1: data_read = '1;
                IDX_BUS:  data_read = '0;
                IDX_PC:   data_read = pc;
                default:  data_read = gp_regs[addr_read];
            endcase
        end
    end

    assign pc_out    = pc;
    assign reg_h_out = gp_regs[IDX_H];

endmodule

// File: tb/tb_core_register_file.sv
// tb/tb_core_register_file.sv - randomized and directed bench for core_register_file against an array model
module tb_core_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr_read;
    logic [3:0]  addr_write;
    logic [15:0] data_write;
    logic        write_enable;
    logic [15:0] bus_datain;
    logic        bus_fromin;
    logic        pc_inc;
    logic [15:0] data_read;
    logic [15:0] pc_out;
    logic [15:0] reg_h_out;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model: plain 16-entry array; index 15 is the PC, constant slots never change.
    logic [15:0] mem [16];

    core_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .addr_read    (addr_read),
        .addr_write   (addr_write),
        .data_write   (data_write),
        .write_enable (write_enable),
        .bus_datain   (bus_datain),
        .bus_fromin   (bus_fromin),
        .pc_inc       (pc_inc),
        .data_read    (data_read),
        .pc_out       (pc_out),
        .reg_h_out    (reg_h_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_read(input logic [3:0] a);
        if (bus_fromin) return bus_datain;
        case (a)
            4'h0:    return 16'h0000;
            4'h1:    return 16'h0001;
            4'h2:    return 16'hFFFF;
            4'hE:    return 16'h0000;
            default: return mem[a];
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        end else begin
            if (pc_inc && !(write_enable && addr_write == 4'hF)) mem[15] = mem[15] + 16'd1;
            if (write_enable && !(addr_write inside {4'h0, 4'h1, 4'h2, 4'hE}))
                mem[addr_write] = data_write;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_data_read", data_read, model_read(addr_read));
            check("cyc_pc_out", pc_out, mem[15]);
            check("cyc_reg_h_out", reg_h_out, mem[10]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        write_enable = 1'b1;
        addr_write   = a;
        data_write   = d;
        tick();
        write_enable = 1'b0;
    endtask

    logic [15:0] exp_tab [16];

    initial begin
        rst = 1'b1; addr_read = '0; addr_write = '0; data_write = '0;
        write_enable = 1'b0; bus_datain = '0; bus_fromin = 1'b0; pc_inc = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;

        addr_read = 4'h3; #1 check("rst_read_a", data_read, 16'h0000);
        addr_read = 4'h1; #1 check("rst_read_one", data_read, 16'h0001);
        addr_read = 4'h2; #1 check("rst_read_neg1", data_read, 16'hFFFF);
        check("rst_pc", pc_out, 16'h0000);
        check("rst_reg_h", reg_h_out, 16'h0000);

        for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 16; i++) exp_tab[i] = 16'h1000 + 16'(i);
        exp_tab[0] = 16'h0000; exp_tab[1] = 16'h0001; exp_tab[2] = 16'hFFFF; exp_tab[14] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            addr_read = 4'(i);
            #1 check($sformatf("all_read_%0d", i), data_read, exp_tab[i]);
        end
        check("all_pc", pc_out, 16'h100F);
        check("all_reg_h", reg_h_out, 16'h100A);

        wr(4'hF, 16'h0010);
        pc_inc = 1'b1; tick(); tick(); tick(); pc_inc = 1'b0;
        check("inc3", pc_out, 16'h0013);
        wr(4'hF, 16'hFFFF);
        pc_inc = 1'b1; tick(); pc_inc = 1'b0;
        check("inc_wrap", pc_out, 16'h0000);

        wr(4'hF, 16'h0020);
        pc_inc = 1'b1; wr(4'hF, 16'h0400); pc_inc = 1'b0;
        check("jump_wins", pc_out, 16'h0400);
        wr(4'hF, 16'h0020);
        pc_inc = 1'b1; wr(4'h3, 16'h5555); pc_inc = 1'b0;
        check("inc_with_gp_write", pc_out, 16'h0021);
        addr_read = 4'h3; #1 check("gp_write_with_inc", data_read, 16'h5555);

        wr(4'h5, 16'h1234);
        addr_read = 4'h5; bus_datain = 16'hBEEF; bus_fromin = 1'b1;
        #1 check("bus_on", data_read, 16'hBEEF);
        bus_fromin = 1'b0;
        #1 check("bus_off", data_read, 16'h1234);

        wr(4'h4, 16'h0001);
        addr_read = 4'h4; write_enable = 1'b1; addr_write = 4'h4; data_write = 16'h0002;
        #1 check("rdw_before", data_read, 16'h0001);
        tick(); write_enable = 1'b0;
        check("rdw_after", data_read, 16'h0002);

        rst = 1'b1; write_enable = 1'b1; addr_write = 4'h5; data_write = 16'hFFFF; pc_inc = 1'b1;
        tick();
        rst = 1'b0; write_enable = 1'b0; pc_inc = 1'b0;
        check("midrst_pc", pc_out, 16'h0000);
        check("midrst_reg_h", reg_h_out, 16'h0000);
        addr_read = 4'h5; #1 check("midrst_read5", data_read, 16'h0000);

        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            addr_read    = 4'($urandom_range(0, 15));
            addr_write   = 4'($urandom_range(0, 15));
            data_write   = 16'($urandom);
            write_enable = ($urandom_range(0, 2) != 0);
            bus_datain   = 16'($urandom);
            bus_fromin   = ($urandom_range(0, 7) == 0);
            pc_inc       = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) data_write = 16'hFFFF;
            tick();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_register_file.md
Name: core_register_file

Overview:
- 16-entry, 16-bit architectural register file for the MCPC core.
- Provides:
  - one combinational read port;
  - one synchronous write port;
  - an auto-incrementing program counter (PC);
  - an external-bus data injection path.
- Sits between the CPU control FSM and the register write-data arbitration logic.
- Exports PC (instruction fetch address) and register H (debug display) continuously.

Parameters:
- DATA_WIDTH, 16, width of every register and data port.
- PC_RESET, 16'h0000, PC value after reset.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- addr_read  in  4  read-port register index.
- addr_write  in  4  write-port register index.
- data_write  in  16  write data.
- write_enable  in  1  commit data_write to addr_write on the next rising edge.
- bus_datain  in  16  external bus data.
- bus_fromin  in  1  when high, the read port returns bus_datain.
- pc_inc  in  1  increment PC by 1 on each rising edge while high.
- data_read  out  16  combinational read data.
- pc_out  out  16  current PC register value.
- reg_h_out  out  16  current register H value.

Behaviour:
- Register map (index: name, semantics):
  - 0x0 ZERO: reads 16'h0000; writes ignored.
  - 0x1 ONE: reads 16'h0001; writes ignored.
  - 0x2 NEG1: reads 16'hFFFF; writes ignored.
  - 0x3–0xA: A, B, C, D, E, F, G, H; general purpose, read/write.
  - 0xB SCR1, 0xC SCR2, 0xD SP: general purpose, read/write.
  - 0xE BUS: reads 16'h0000 (unless bus_fromin); writes ignored.
  - 0xF PC: read/write; auto-increment.
- Reset: on a rising edge with rst=1:
  - all storage registers clear to 0; PC becomes PC_RESET;
  - write_enable and pc_inc are ignored that cycle.
  - Outputs follow immediately: pc_out=0, reg_h_out=0, data_read=constant or 0 per map.
- Read port is purely combinational, zero latency:
  - bus_fromin=1 → data_read = bus_datain, regardless of addr_read;
  - otherwise data_read = value mapped at addr_read.
- Write port: on a rising edge with write_enable=1, the register at addr_write takes data_write. Writes to indices 0x0, 0x1, 0x2, 0xE have no effect.
- Read during write, same index, same cycle: data_read shows the old value until after the edge. No bypass.
- PC update per rising edge, in priority order:
  1. rst → PC_RESET.
  2. write_enable=1 and addr_write=0xF → data_write. The write wins and the increment is suppressed, so jumps land exactly on the target.
  3. pc_inc=1 → PC + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  4. Otherwise hold.
- pc_inc is level-sensitive: held high for N edges → PC advances by N. No edge detection.
- Simultaneous pc_inc with a write to a non-PC register: both take effect.
- pc_out = PC register; reg_h_out = register 0xA. Both combinational from storage and update in the same cycle as the edge.
- No X propagation: all storage is defined after the first reset edge.

Test Plan:
- Reset: run with rst=1 for 2 edges, then rst=0 → pc_out=0, reg_h_out=0; data_read: addr 0x3 → 0, addr 0x1 → 1, addr 0x2 → 16'hFFFF.
- Write/read all registers: write 16'h1000+i to each index 0–15 with pc_inc=0 → reads are:
  - 0x0 → 0, 0x1 → 1, 0x2 → 16'hFFFF, 0xE → 0;
  - 0xF → 16'h100F (pc_out also 16'h100F);
  - reg_h_out → 16'h100A;
  - other indices return written value.
- PC increment: pc_inc high for 3 edges from PC=16'h0010 → pc_out=16'h0013. From PC=16'hFFFF, one edge → 16'h0000.
- Write vs increment: PC=16'h0020, pc_inc=1 and write 16'h0400 to 0xF on same edge → pc_out=16'h0400, not 16'h0401. Same edge with write to 0x3 instead → reg 0x3 updated and PC=16'h0021.
- Bus path: bus_datain=16'hBEEF, bus_fromin=1, addr_read=0x5 (holding 16'h1234) → data_read=16'hBEEF. Drop bus_fromin → 16'h1234 in the same cycle.
- Read-during-write and reset mid-operation:
  - addr_read=addr_write=0x4, old value 16'h0001, write 16'h0002 → data_read=16'h0001 before the edge, 16'h0002 after.
  - rst asserted together with write_enable and pc_inc → all registers 0, PC=0.
